prog_mem_arb: RTL and testbench

- Program memory that sits directly downstream of the SPI ROM loader controller's system bus (addr/wdata/wr_ena/rdata).
- Holds the 8-bit computer's program image and arbitrates between two users:
  - the loader bus, which writes and reads back the image over SPI;
  - the CPU instruction-fetch port.
- A boot FSM holds the CPU halted until a load session has completed.

---
 rtl/prog_mem_arb.sv | 154 +++++++++++++++
 tb/tb_prog_mem_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_arb.sv
// prog_mem_arb: program memory shared between the SPI ROM loader bus and the
// CPU instruction-fetch port, with a boot FSM that keeps the CPU halted until
// a load session has written at least one word.
// Optional feature: define PROG_MEM_CLEAR_ON_RST_EN to zero the whole array
// after every reset (ST_CLEAR sweep) and flag loader writes dropped meanwhile.
module prog_mem_arb #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      ld_active,
  input  logic [MEM_ADDR_WIDTH-1:0] ld_addr,
  input  logic [MEM_DATA_WIDTH-1:0] ld_wdata,
  input  logic                      ld_wr_ena,
  output logic [MEM_DATA_WIDTH-1:0] ld_rdata,
  input  logic                      cpu_rd_req,
  input  logic [MEM_ADDR_WIDTH-1:0] cpu_addr,
  output logic                      cpu_rd_gnt,
  output logic [MEM_DATA_WIDTH-1:0] cpu_rd_data,
  output logic                      cpu_rd_vld,
  output logic                      cpu_halt,
  output logic [MEM_ADDR_WIDTH:0]   ld_wr_cnt,
  output logic                      ld_drop_err
);

  localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
  localparam int CNT_W = MEM_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
`ifdef PROG_MEM_CLEAR_ON_RST_EN
    ST_CLEAR = 2'd0,
`endif
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  state_t                    state;
  logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];

  logic                      in_clear;
  logic                      ld_wr_acc;
  logic                      session_start;
  logic                      mem_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata;

  // Status counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign ld_wr_acc     = ld_wr_ena & ~in_clear;
  assign session_start = ld_active & ((state == ST_IDLE) | (state == ST_RUN));
  // Loader writes win the single array port; the CPU simply waits a cycle.
  assign cpu_rd_gnt    = cpu_rd_req & (state == ST_RUN) & ~ld_wr_ena;

`ifdef PROG_MEM_CLEAR_ON_RST_EN
  logic [MEM_ADDR_WIDTH-1:0] clr_addr;
  logic                      drop_err;

  assign in_clear    = (state == ST_CLEAR);
  assign ld_drop_err = drop_err;
  // While clearing, the sweep owns the write port and the loader is locked out.
  assign mem_we      = in_clear | ld_wr_acc;
  assign mem_waddr   = in_clear ? clr_addr : ld_addr;
  assign mem_wdata   = in_clear ? '0 : ld_wdata;

  // Clear sweep address and sticky record of loader writes lost to the sweep.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clr_addr <= '0;
      drop_err <= 1'b0;
    end else begin
      if (in_clear) clr_addr <= clr_addr + 1'b1;
      if (in_clear && ld_wr_ena) drop_err <= 1'b1;
    end
  end
`else
  assign in_clear    = 1'b0;
  assign ld_drop_err = 1'b0;
  assign mem_we      = ld_wr_acc;
  assign mem_waddr   = ld_addr;
  assign mem_wdata   = ld_wdata;
`endif

  // Array write port; contents deliberately survive reset.
  always_ff @(posedge sys_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read ports: loader readback is write-first, CPU data holds between fetches.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ld_rdata    <= '0;
      cpu_rd_data <= '0;
      cpu_rd_vld  <= 1'b0;
    end else begin
      ld_rdata   <= (mem_we && (mem_waddr == ld_addr)) ? mem_wdata : mem[ld_addr];
      cpu_rd_vld <= cpu_rd_gnt;
      if (cpu_rd_gnt) cpu_rd_data <= mem[cpu_addr];
    end
  end

  // Boot FSM with registered cpu_halt, plus the per-session write counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
`ifdef PROG_MEM_CLEAR_ON_RST_EN
      state <= ST_CLEAR;
`else
      state <= ST_IDLE;
`endif
      cpu_halt  <= 1'b1;
      ld_wr_cnt <= '0;
    end else begin
      if (session_start) ld_wr_cnt <= {{(CNT_W-1){1'b0}}, ld_wr_acc};
      else if (ld_wr_acc) ld_wr_cnt <= sat_inc(ld_wr_cnt);

      case (state)
`ifdef PROG_MEM_CLEAR_ON_RST_EN
        ST_CLEAR: begin
          if (&clr_addr) state <= ST_IDLE;
        end
`endif
        ST_IDLE: begin
          if (ld_active) state <= ST_LOAD;
        end
        ST_LOAD: begin
          // An empty session leaves nothing to run, so fall back to idle.
          if (!ld_active) begin
            if ((ld_wr_cnt != '0) || ld_wr_acc) begin
              state    <= ST_RUN;
              cpu_halt <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_RUN: begin
          if (ld_active) begin
            state    <= ST_LOAD;
            cpu_halt <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cpu_halt <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_arb.sv
// Bench for prog_mem_arb: directed steps plus randomized sessions, checked
// against a cycle-level behavioural model (array, phase, counters).
`timescale 1ns/1ps
module tb_prog_mem_arb;

`ifdef PROG_MEM_CLEAR_ON_RST_EN
  localparam int AW = 4;
`else
  localparam int AW = 8;
`endif
  localparam int DW      = 8;
  localparam int DEPTH   = 1 << AW;
  localparam int CNT_MAX = (1 << (AW + 1)) - 1;
  localparam int P_CLEAR = 0, P_IDLE = 1, P_LOAD = 2, P_RUN = 3;
  localparam logic [AW-1:0] A10 = AW'('h10);
  localparam logic [AW-1:0] A11 = AW'('h11);

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          ld_active;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_wr_ena;
  logic [DW-1:0] ld_rdata;
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rd_gnt;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rd_vld;
  logic          cpu_halt;
  logic [AW:0]   ld_wr_cnt;
  logic          ld_drop_err;

  always #5 sys_clk = ~sys_clk;

  prog_mem_arb #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ld_active(ld_active),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_wr_ena(ld_wr_ena),
    .ld_rdata(ld_rdata), .cpu_rd_req(cpu_rd_req), .cpu_addr(cpu_addr),
    .cpu_rd_gnt(cpu_rd_gnt), .cpu_rd_data(cpu_rd_data), .cpu_rd_vld(cpu_rd_vld),
    .cpu_halt(cpu_halt), .ld_wr_cnt(ld_wr_cnt), .ld_drop_err(ld_drop_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_mem   [DEPTH];
  bit m_known [DEPTH];
  int m_phase, m_clr, m_cnt, m_rd_data, m_ld_rdata;
  bit m_halt, m_vld, m_drop, m_rd_known, m_ld_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
`ifdef PROG_MEM_CLEAR_ON_RST_EN
    m_phase = P_CLEAR;
`else
    m_phase = P_IDLE;
`endif
    m_clr = 0; m_cnt = 0; m_halt = 1'b1; m_vld = 1'b0; m_drop = 1'b0;
    m_rd_data = 0; m_rd_known = 1'b1; m_ld_rdata = 0; m_ld_known = 1'b1;
  endtask

  task automatic check_outputs();
    chk("halt", cpu_halt, m_halt);
    chk("vld", cpu_rd_vld, m_vld);
    chk("wr_cnt", ld_wr_cnt, m_cnt);
    chk("drop_err", ld_drop_err, m_drop);
    if (m_ld_known) chk("ld_rdata", ld_rdata, m_ld_rdata);
    if (m_rd_known) chk("cpu_rd_data", cpu_rd_data, m_rd_data);
  endtask

  // One clock: check the grant, advance the model with the current inputs,
  // clock the DUT, then compare registered outputs.
  task automatic step();
    bit gnt_exp, acc;
    int nxt;
    #1;
    gnt_exp = cpu_rd_req && (m_phase == P_RUN) && !ld_wr_ena;
    chk("gnt", cpu_rd_gnt, gnt_exp);
    if (gnt_exp) begin
      m_rd_data  = m_mem[cpu_addr];
      m_rd_known = m_known[cpu_addr];
    end
    m_vld = gnt_exp;
    acc = ld_wr_ena && (m_phase != P_CLEAR);
    if (m_phase == P_CLEAR) begin
      if (ld_wr_ena) m_drop = 1'b1;
      m_mem[m_clr] = 0;
      m_known[m_clr] = 1'b1;
    end
    if (acc) begin
      m_mem[ld_addr] = ld_wdata;
      m_known[ld_addr] = 1'b1;
    end
    m_ld_rdata = m_mem[ld_addr];
    m_ld_known = m_known[ld_addr];
    if (ld_active && (m_phase == P_IDLE || m_phase == P_RUN)) m_cnt = acc;
    else if (acc && m_cnt < CNT_MAX) m_cnt++;
    nxt = m_phase;
    case (m_phase)
      P_CLEAR: if (m_clr == DEPTH - 1) nxt = P_IDLE; else m_clr++;
      P_IDLE:  if (ld_active) nxt = P_LOAD;
      P_LOAD:  if (!ld_active) nxt = (m_cnt != 0) ? P_RUN : P_IDLE;
      default: if (ld_active) nxt = P_LOAD;
    endcase
    m_phase = nxt;
    m_halt = (nxt != P_RUN);
    @(posedge sys_clk);
    #1;
    check_outputs();
  endtask

`ifdef PROG_MEM_CLEAR_ON_RST_EN
  task automatic run_clear(input int pulse_at);
    cpu_rd_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_wr_ena = (i == pulse_at);
      ld_addr = AW'(3);
      ld_wdata = 8'h5A;
      step();
    end
    ld_wr_ena = 1'b0;
    cpu_rd_req = 1'b0;
  endtask
`endif

  initial begin
    bit last_blocked;
    int nwr;
    sys_rst_n = 1'b0; ld_active = 1'b0; ld_addr = '0; ld_wdata = '0;
    ld_wr_ena = 1'b0; cpu_rd_req = 1'b0; cpu_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_known[i] = 1'b0; end
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check_outputs();
    chk("rst_halt", cpu_halt, 1);
    sys_rst_n = 1'b1;
`ifdef PROG_MEM_CLEAR_ON_RST_EN
    run_clear(-1);
`endif
    step();

    // Test 1: two-write session, then release to run
    ld_active = 1'b1; step();
    ld_wr_ena = 1'b1; ld_addr = A10; ld_wdata = 8'hA5; step();
    ld_addr = A11; ld_wdata = 8'h3C; step();
    chk("t1_rdback", ld_rdata, 8'h3C);
    ld_wr_ena = 1'b0; step();
    chk("t1_halt_load", cpu_halt, 1);
    ld_active = 1'b0; step();
    chk("t1_cnt", ld_wr_cnt, 2);
    chk("t1_halt_run", cpu_halt, 0);

    // Test 3: three back-to-back fetches
    cpu_addr = A10; cpu_rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_vld", cpu_rd_vld, 1);
      chk("t3_data", cpu_rd_data, 8'hA5);
    end
    cpu_rd_req = 1'b0; step();
    chk("t3_vld_end", cpu_rd_vld, 0);

    // Test 4: loader write blocks a same-cycle fetch of the same word
    cpu_addr = A11; cpu_rd_req = 1'b1;
    ld_wr_ena = 1'b1; ld_addr = A11; ld_wdata = 8'h77;
    #1; chk("t4_gnt_blocked", cpu_rd_gnt, 0);
    step();
    ld_wr_ena = 1'b0;
    #1; chk("t4_gnt_free", cpu_rd_gnt, 1);
    step();
    cpu_rd_req = 1'b0;
    chk("t4_data", cpu_rd_data, 8'h77);
    chk("t4_vld", cpu_rd_vld, 1);
    chk("t4_cnt", ld_wr_cnt, 3);
    step();

    // Test 2: empty session leaves the CPU halted
    ld_active = 1'b1; step();
    chk("t2_halt_rise", cpu_halt, 1);
    repeat (19) step();
    ld_active = 1'b0; step();
    chk("t2_halt", cpu_halt, 1);
    chk("t2_cnt", ld_wr_cnt, 0);
    cpu_rd_req = 1'b1; cpu_addr = A10; step();
    cpu_rd_req = 1'b0; step();

    // Fill every word and overrun the counter to saturation
    ld_active = 1'b1; step();
    for (int i = 0; i < CNT_MAX + 20; i++) begin
      ld_wr_ena = 1'b1; ld_addr = AW'(i % DEPTH); ld_wdata = DW'($urandom_range(0, 255));
      step();
    end
    ld_wr_ena = 1'b0; step();
    chk("sat_cnt", ld_wr_cnt, CNT_MAX);
    ld_active = 1'b0; step();

    // Randomized rounds: random run traffic, then a random session
    last_blocked = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 150; i++) begin
        if (!last_blocked) begin
          cpu_rd_req = 1'($urandom_range(0, 1));
          cpu_addr = AW'($urandom_range(0, DEPTH - 1));
        end
        ld_wr_ena = ($urandom_range(0, 3) == 0);
        ld_addr = AW'($urandom_range(0, DEPTH - 1));
        ld_wdata = DW'($urandom_range(0, 255));
        last_blocked = cpu_rd_req && ld_wr_ena && (m_phase == P_RUN);
        step();
      end
      cpu_rd_req = 1'b0; ld_wr_ena = 1'b0; last_blocked = 1'b0;
      ld_active = 1'b1; step();
      nwr = $urandom_range(0, 30);
      for (int i = 0; i < nwr; i++) begin
        ld_wr_ena = ($urandom_range(0, 1) == 1);
        ld_addr = AW'($urandom_range(0, DEPTH - 1));
        ld_wdata = DW'($urandom_range(0, 255));
        step();
      end
      ld_wr_ena = 1'b0; step();
      ld_active = 1'b0; step();
    end

    // Guarantee run state before the reset test
    ld_active = 1'b1; step();
`ifdef PROG_MEM_CLEAR_ON_RST_EN
    for (int i = 0; i < DEPTH; i++) begin
      ld_wr_ena = 1'b1; ld_addr = AW'(i); ld_wdata = 8'hFF; step();
    end
`else
    ld_wr_ena = 1'b1; ld_addr = A10; ld_wdata = 8'hA5; step();
`endif
    ld_wr_ena = 1'b0; step();
    ld_active = 1'b0; step();
    chk("t5_running", cpu_halt, 0);

    // Test 5: asynchronous reset with a fetch result due next cycle
    cpu_addr = A10; cpu_rd_req = 1'b1; step();
    chk("t5_vld_before", cpu_rd_vld, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    cpu_rd_req = 1'b0;
    check_outputs();
    chk("t5_gnt", cpu_rd_gnt, 0);
    @(posedge sys_clk);
    #1;
    check_outputs();
    sys_rst_n = 1'b1;

`ifdef PROG_MEM_CLEAR_ON_RST_EN
    // Test 6: clear sweep over an all-0xFF image, loader write dropped at cycle 5
    run_clear(5);
    chk("t6_drop", ld_drop_err, 1);
    chk("t6_cnt", ld_wr_cnt, 0);
    for (int i = 0; i < DEPTH; i++) begin
      ld_addr = AW'(i); step();
      chk("t6_zero", ld_rdata, 0);
    end
`else
    step();
    for (int i = 0; i < 8; i++) begin
      ld_addr = AW'(i * 7); step();
    end
    ld_addr = A10; step();
    chk("t5_mem_kept", ld_rdata, 8'hA5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
